// File: rtl/pipe_pq_pkg.sv
// Shared types and helpers for the pipelined binary-heap priority queue.
package pipe_pq_pkg;

  typedef enum logic [1:0] {
    OpNop  = 2'd0,
    OpEnq  = 2'd1,
    OpDeq  = 2'd2,
    OpRepl = 2'd3
  } op_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  // Number of nodes in a subtree rooted at `level` of a `depth`-level tree.
  function automatic int unsigned subtree_cap(int unsigned depth, int unsigned level);
    return (32'd1 << (depth - level)) - 32'd1;
  endfunction

endpackage

// File: rtl/pipe_pq_level.sv
// One heap level: node storage, occupancy, subtree free capacity and the op register
// that carries the operation on to the next level.
module pipe_pq_level
  import pipe_pq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned KEY_WID = 32,
  parameter int unsigned DEPTH   = 6,
  parameter int unsigned LEVEL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] val_i,
  input  logic [DEPTH-1:0] idx_i,
  input  logic [WIDTH-1:0] ch_val_i [2],
  input  logic             ch_occ_i [2],
  input  logic [DEPTH-1:0] ch_cap_i [2],
  input  logic [DEPTH-1:0] par_idx_i,
  output logic [WIDTH-1:0] kid_val_o [2],
  output logic             kid_occ_o [2],
  output logic [DEPTH-1:0] kid_cap_o [2],
  output op_e              op_o,
  output logic [WIDTH-1:0] val_o,
  output logic [DEPTH-1:0] idx_o
);

  localparam int unsigned      Nodes   = 1 << LEVEL;
  localparam logic [DEPTH-1:0] CapInit = DEPTH'(subtree_cap(DEPTH, LEVEL));

  logic [WIDTH-1:0] val_q [Nodes];
  logic             occ_q [Nodes];
  logic [DEPTH-1:0] cap_q [Nodes];

  op_e              op_q, op_d;
  logic [WIDTH-1:0] fwd_val_q, fwd_val_d;
  logic [DEPTH-1:0] fwd_idx_q, fwd_idx_d;

  logic [WIDTH-1:0] cur_val, new_val;
  logic             cur_occ, new_occ;
  logic [DEPTH-1:0] cur_cap, new_cap;
  logic             dir, any_ch, swap;

  function automatic logic key_lt(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    return a[KEY_WID-1:0] < b[KEY_WID-1:0];
  endfunction

  // Read port for the level above: the two children of its active node.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      kid_val_o[s] = '0;
      kid_occ_o[s] = 1'b0;
      kid_cap_o[s] = '0;
      for (int n = 0; n < Nodes; n++) begin
        if ({par_idx_i, s[0]} == (DEPTH + 1)'(n)) begin
          kid_val_o[s] = val_q[n];
          kid_occ_o[s] = occ_q[n];
          kid_cap_o[s] = cap_q[n];
        end
      end
    end
  end

  always_comb begin
    cur_val = '0;
    cur_occ = 1'b0;
    cur_cap = '0;
    for (int n = 0; n < Nodes; n++) begin
      if (idx_i == DEPTH'(n)) begin
        cur_val = val_q[n];
        cur_occ = occ_q[n];
        cur_cap = cap_q[n];
      end
    end
  end

  // Smaller valid child; ties go left.
  assign any_ch = ch_occ_i[0] | ch_occ_i[1];
  assign dir    = (ch_occ_i[1] && (!ch_occ_i[0] || key_lt(ch_val_i[1], ch_val_i[0]))) ?
                  RIGHT : LEFT;
  assign swap   = key_lt(val_i, cur_val);

  always_comb begin
    new_val   = cur_val;
    new_occ   = cur_occ;
    new_cap   = cur_cap;
    op_d      = OpNop;
    fwd_val_d = val_i;
    fwd_idx_d = {idx_i[DEPTH-2:0], dir};
    unique case (op_i)
      OpEnq: begin
        new_cap = cur_cap - 1'b1;
        if (!cur_occ) begin
          new_val = val_i;
          new_occ = 1'b1;
        end else begin
          new_val   = swap ? val_i : cur_val;
          fwd_val_d = swap ? cur_val : val_i;
          op_d      = OpEnq;
          fwd_idx_d = {idx_i[DEPTH-2:0], (ch_cap_i[0] != '0) ? LEFT : RIGHT};
        end
      end
      OpDeq: begin
        new_cap = cur_cap + 1'b1;
        if (any_ch) begin
          new_val = ch_val_i[dir];
          op_d    = OpDeq;
        end else begin
          new_occ = 1'b0;
        end
      end
      OpRepl: begin
        if (any_ch && key_lt(ch_val_i[dir], val_i)) begin
          new_val = ch_val_i[dir];
          op_d    = OpRepl;
        end else begin
          new_val = val_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < Nodes; n++) begin
        val_q[n] <= '0;
        occ_q[n] <= 1'b0;
        cap_q[n] <= CapInit;
      end
      op_q      <= OpNop;
      fwd_val_q <= '0;
      fwd_idx_q <= '0;
    end else begin
      for (int n = 0; n < Nodes; n++) begin
        if (op_i != OpNop && idx_i == DEPTH'(n)) begin
          val_q[n] <= new_val;
          occ_q[n] <= new_occ;
          cap_q[n] <= new_cap;
        end
      end
      op_q      <= op_d;
      fwd_val_q <= fwd_val_d;
      fwd_idx_q <= fwd_idx_d;
    end
  end

  assign op_o  = op_q;
  assign val_o = fwd_val_q;
  assign idx_o = fwd_idx_q;

endmodule

// File: rtl/pipe_pq.sv
// Pipelined heap priority queue: accept/decode logic, element counter and the level chain.
module pipe_pq
  import pipe_pq_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned KEY_WID = 32,
  parameter int unsigned DEPTH   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic             deq,
  input  logic [WIDTH-1:0] inp_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] top_data,
  output logic             top_valid,
  output logic [DEPTH:0]   elem_cnt,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             udf_err
);

  localparam logic [DEPTH:0] CapCnt = (DEPTH + 1)'(subtree_cap(DEPTH, 0));

  logic           busy_q, acc;
  logic [DEPTH:0] cnt_q, cnt_d;
  logic           ovf_q, ovf_d, udf_q, udf_d;
  op_e            acc_op;

  op_e              op_lnk  [DEPTH+1];
  logic [WIDTH-1:0] val_lnk [DEPTH+1];
  logic [DEPTH-1:0] idx_lnk [DEPTH+1];
  logic [DEPTH-1:0] par_lnk [DEPTH];
  logic [WIDTH-1:0] kid_val [DEPTH+1][2];
  logic             kid_occ [DEPTH+1][2];
  logic [DEPTH-1:0] kid_cap [DEPTH+1][2];

  assign in_ready = ~busy_q;
  assign acc      = in_ready & (enq | deq);
  assign full     = (cnt_q == CapCnt);
  assign empty    = (cnt_q == '0);

  // enq&deq on an empty queue degrades to a plain insert.
  always_comb begin
    acc_op = OpNop;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (acc) begin
      if (enq && deq && !empty) begin
        acc_op = OpRepl;
      end else if (enq) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          acc_op = OpEnq;
          cnt_d  = cnt_q + 1'b1;
        end
      end else if (empty) begin
        udf_d = 1'b1;
      end else begin
        acc_op = OpDeq;
        cnt_d  = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      busy_q <= acc;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  assign op_lnk[0]  = acc_op;
  assign val_lnk[0] = inp_data;
  assign idx_lnk[0] = '0;

  for (genvar s = 0; s < 2; s++) begin : g_tie
    assign kid_val[DEPTH][s] = '0;
    assign kid_occ[DEPTH][s] = 1'b0;
    assign kid_cap[DEPTH][s] = '0;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
    if (k == 0) begin : g_root
      assign par_lnk[k] = '0;
    end else begin : g_inner
      assign par_lnk[k] = idx_lnk[k-1];
    end

    pipe_pq_level #(
      .WIDTH  (WIDTH),
      .KEY_WID(KEY_WID),
      .DEPTH  (DEPTH),
      .LEVEL  (k)
    ) u_level (
      .clk      (clk),
      .rst      (rst),
      .op_i     (op_lnk[k]),
      .val_i    (val_lnk[k]),
      .idx_i    (idx_lnk[k]),
      .ch_val_i (kid_val[k+1]),
      .ch_occ_i (kid_occ[k+1]),
      .ch_cap_i (kid_cap[k+1]),
      .par_idx_i(par_lnk[k]),
      .kid_val_o(kid_val[k]),
      .kid_occ_o(kid_occ[k]),
      .kid_cap_o(kid_cap[k]),
      .op_o     (op_lnk[k+1]),
      .val_o    (val_lnk[k+1]),
      .idx_o    (idx_lnk[k+1])
    );
  end

  // Level 0 read port with parent index 0 exposes the root as child slot 0.
  assign top_data  = kid_val[0][0];
  assign top_valid = kid_occ[0][0];
  assign elem_cnt  = cnt_q;
  assign ovf_err   = ovf_q;
  assign udf_err   = udf_q;

endmodule

// File: tb/tb_pipe_pq.sv
// Randomized and directed bench for pipe_pq against a multiset reference model.
module tb_pipe_pq;

  localparam int W   = 16;
  localparam int K   = 8;
  localparam int D   = 3;
  localparam int CAP = 7;

  logic         clk, rst, enq, deq;
  logic [W-1:0] inp_data, top_data;
  logic         in_ready, top_valid, full, empty, ovf_err, udf_err;
  logic [D:0]   elem_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mdl[$];
  bit           m_ovf, m_udf;

  pipe_pq #(
    .WIDTH  (W),
    .KEY_WID(K),
    .DEPTH  (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enq      (enq),
    .deq      (deq),
    .inp_data (inp_data),
    .in_ready (in_ready),
    .top_data (top_data),
    .top_valid(top_valid),
    .elem_cnt (elem_cnt),
    .full     (full),
    .empty    (empty),
    .ovf_err  (ovf_err),
    .udf_err  (udf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_key();
    int m = 1 << K;
    foreach (mdl[i]) if (int'(mdl[i][K-1:0]) < m) m = int'(mdl[i][K-1:0]);
    return m;
  endfunction

  function automatic bit has_val(input logic [W-1:0] v);
    foreach (mdl[i]) if (mdl[i] === v) return 1'b1;
    return 1'b0;
  endfunction

  // Remove one minimum-key entry; among tied keys prefer the one currently shown at the root.
  function automatic void rm_min(input logic [W-1:0] pref);
    int mk = min_key();
    int pick = -1;
    foreach (mdl[i]) if (int'(mdl[i][K-1:0]) == mk && pick < 0) pick = i;
    foreach (mdl[i]) if (mdl[i] === pref && int'(pref[K-1:0]) == mk) pick = i;
    mdl.delete(pick);
  endfunction

  task automatic verify();
    chk("in_ready_low", 32'(in_ready), 32'd0);
    chk("elem_cnt", 32'(elem_cnt), 32'(mdl.size()));
    chk("full", 32'(full), 32'(mdl.size() == CAP));
    chk("empty", 32'(empty), 32'(mdl.size() == 0));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    chk("udf_err", 32'(udf_err), 32'(m_udf));
    chk("top_valid", 32'(top_valid), 32'(mdl.size() != 0));
    if (mdl.size() != 0) begin
      chk("top_key", 32'(top_data[K-1:0]), 32'(min_key()));
      chk("top_intact", 32'(has_val(top_data)), 32'd1);
    end
  endtask

  // Issue one op, then present an enq request during the busy cycle that must be ignored.
  task automatic issue(input bit e, input bit d, input logic [W-1:0] v);
    logic [W-1:0] pref;
    @(negedge clk);
    chk("in_ready_high", 32'(in_ready), 32'd1);
    pref     = top_data;
    enq      = e;
    deq      = d;
    inp_data = v;
    if (e && d && mdl.size() != 0) begin
      rm_min(pref);
      mdl.push_back(v);
    end else if (e) begin
      if (mdl.size() == CAP) m_ovf = 1'b1;
      else mdl.push_back(v);
    end else if (d) begin
      if (mdl.size() == 0) m_udf = 1'b1;
      else rm_min(pref);
    end
    @(negedge clk);
    enq      = 1'b1;
    deq      = 1'($urandom);
    inp_data = W'($urandom);
    verify();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enq = 1'b0;
      deq = 1'b0;
    end
  endtask

  task automatic do_reset();
    enq = 1'b0;
    deq = 1'b0;
    rst = 1'b1;
    mdl.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'(elem_cnt), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_top_valid", 32'(top_valid), 32'd0);
    chk("rst_top_data", 32'(top_data), 32'd0);
    chk("rst_flags", {30'd0, ovf_err, udf_err}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] v;
    int r;
    int s1_enq[4] = '{5, 3, 9, 1};
    int s1_top[4] = '{5, 3, 3, 1};
    int s1_deq[3] = '{3, 5, 9};
    rst = 1'b1;
    enq = 1'b0;
    deq = 1'b0;
    inp_data = '0;
    repeat (2) @(negedge clk);
    do_reset();

    // Ordered inserts then drain.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, W'(s1_enq[i]));
      chk("s1_top", 32'(top_data), 32'(s1_top[i]));
    end
    chk("s1_cnt", 32'(elem_cnt), 32'd4);
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b1, '0);
      chk("s1_deq_top", 32'(top_data), 32'(s1_deq[i]));
    end
    issue(1'b0, 1'b1, '0);
    chk("s1_drained", {30'd0, top_valid, empty}, 32'd1);

    // Fill, overflow, replace-when-full.
    do_reset();
    for (int i = 0; i < CAP; i++) issue(1'b1, 1'b0, {8'(i), 8'($urandom_range(1, 30))});
    issue(1'b1, 1'b0, 16'h0011);
    chk("s2_ovf", 32'(ovf_err), 32'd1);
    chk("s2_cnt", 32'(elem_cnt), 32'd7);
    issue(1'b1, 1'b1, 16'h5500);
    chk("s2_repl_top", 32'(top_data), 32'h5500);
    chk("s2_repl_cnt", 32'(elem_cnt), 32'd7);

    // Underflow and enq&deq on empty.
    do_reset();
    issue(1'b0, 1'b1, '0);
    chk("s3_udf", 32'(udf_err), 32'd1);
    do_reset();
    issue(1'b1, 1'b1, 16'h0004);
    chk("s3_both_top", 32'(top_data), 32'd4);
    chk("s3_both_udf", 32'(udf_err), 32'd0);
    chk("s3_both_cnt", 32'(elem_cnt), 32'd1);

    // Equal keys with distinct tags.
    do_reset();
    issue(1'b1, 1'b0, 16'hA002);
    issue(1'b1, 1'b0, 16'hB002);
    issue(1'b1, 1'b0, 16'h0007);
    issue(1'b0, 1'b1, '0);
    chk("s5_root_key", 32'(top_data[K-1:0]), 32'd2);
    issue(1'b0, 1'b1, '0);
    chk("s5_last", 32'(top_data), 32'h0007);
    issue(1'b0, 1'b1, '0);

    // Reset while an insert is in flight.
    do_reset();
    for (int i = 0; i < 5; i++) issue(1'b1, 1'b0, W'(10 + i));
    issue(1'b1, 1'b0, 16'h0002);
    do_reset();
    idle(3);
    chk("s6_cnt_idle", 32'(elem_cnt), 32'd0);
    issue(1'b1, 1'b0, 16'h0006);
    chk("s6_top", 32'(top_data), 32'd6);

    // Random mix with small keys to provoke ties.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      v = {8'($urandom), 8'($urandom_range(0, 15))};
      if (r < 5) issue(1'b1, 1'b0, v);
      else if (r < 8) issue(1'b0, 1'b1, v);
      else issue(1'b1, 1'b1, v);
      idle($urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
